// File: rtl/rota_pkg.sv
// Shared types and constants for the route scheduler: FSM states, valid-route set, field width.
package rota_pkg;

  localparam int ROTA_W = 6;

  localparam logic [ROTA_W-1:0] ROTA_A = 6'b111000;
  localparam logic [ROTA_W-1:0] ROTA_B = 6'b100011;
  localparam logic [ROTA_W-1:0] ROTA_C = 6'b100101;
  localparam logic [ROTA_W-1:0] ROTA_D = 6'b100110;

  typedef enum logic [1:0] {
    BOS     = 2'd0,
    KONTROL = 2'd1,
    ILET    = 2'd2,
    RED     = 2'd3
  } durum_t;

  // Error counter sticks at all-ones instead of wrapping.
  function automatic logic [7:0] doyarak_artir(input logic [7:0] d);
    return (d == 8'hFF) ? d : d + 8'd1;
  endfunction

endpackage

// File: rtl/rotadogrula.sv
// Combinational route validator: asserts rota_dogru when the code is one of the four legal routes.
module rotadogrula
  import rota_pkg::*;
(
  input  logic [ROTA_W-1:0] rota,
  output logic              rota_dogru
);

  always_comb begin
    rota_dogru = (rota == ROTA_A) || (rota == ROTA_B) ||
                 (rota == ROTA_C) || (rota == ROTA_D);
  end

endmodule

// File: rtl/rota_planlayici.sv
// Round-robin scheduler that shares one route validator among N_IST requesters and forwards
// valid codes downstream over valid/ready, rejecting invalid or timed-out ones.
module rota_planlayici
  import rota_pkg::*;
#(
  parameter int N_IST   = 4,
  parameter int TIMEOUT = 15
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_IST-1:0]        istek,
  input  logic [ROTA_W*N_IST-1:0] rota_in,
  output logic [N_IST-1:0]        onay,
  output logic [N_IST-1:0]        red,
  output logic                    cikis_gecerli,
  input  logic                    cikis_hazir,
  output logic [ROTA_W-1:0]       cikis_rota,
  output logic [2:0]              cikis_kaynak,
  output logic [7:0]              hata_sayac,
  output logic [1:0]              o_durum
);

  // Downstream handshake: a transfer happens in any cycle where cikis_gecerli and cikis_hazir
  // are both 1; cikis_rota/cikis_kaynak stay stable from cikis_gecerli rising until that cycle.

  durum_t              r_durum, w_durum_nxt;
  logic [2:0]          r_idx, w_idx_nxt;
  logic [2:0]          r_son, w_son_nxt;
  logic [ROTA_W-1:0]   r_rota, w_rota_nxt;
  logic [7:0]          r_sayac, w_sayac_nxt;
  logic [N_IST-1:0]    r_onay, w_onay_nxt;
  logic [N_IST-1:0]    r_red, w_red_nxt;
  logic                r_gecerli, w_gecerli_nxt;
  logic [ROTA_W-1:0]   r_cikis_rota, w_cikis_rota_nxt;
  logic [2:0]          r_kaynak, w_kaynak_nxt;
  logic [7:0]          r_hata, w_hata_nxt;

  logic                w_rota_dogru;
  logic [2:0]          w_sec;
  logic [ROTA_W-1:0]   w_sec_kod;
  logic [N_IST-1:0]    w_tek;

  // First requesting index after the last-served one, wrapping modulo N_IST.
  function automatic logic [2:0] rr_sec(input logic [N_IST-1:0] req, input logic [2:0] son);
    logic [2:0] sec;
    logic       bulundu;
    int         j;
    sec     = '0;
    bulundu = 1'b0;
    for (int k = 1; k <= N_IST; k++) begin
      j = (int'(son) + k) % N_IST;
      if (!bulundu && req[j]) begin
        sec     = 3'(j);
        bulundu = 1'b1;
      end
    end
    return sec;
  endfunction

  rotadogrula u_rotadogrula (
    .rota       (r_rota),
    .rota_dogru (w_rota_dogru)
  );

  always_comb begin
    w_sec     = rr_sec(istek, r_son);
    w_sec_kod = rota_in[ROTA_W*int'(w_sec) +: ROTA_W];
    w_tek     = {{(N_IST-1){1'b0}}, 1'b1} << r_idx;
  end

  always_comb begin
    w_durum_nxt      = r_durum;
    w_idx_nxt        = r_idx;
    w_son_nxt        = r_son;
    w_rota_nxt       = r_rota;
    w_sayac_nxt      = r_sayac;
    w_onay_nxt       = '0;
    w_red_nxt        = '0;
    w_gecerli_nxt    = r_gecerli;
    w_cikis_rota_nxt = r_cikis_rota;
    w_kaynak_nxt     = r_kaynak;
    w_hata_nxt       = r_hata;
    case (r_durum)
      BOS: begin
        // The cycle carrying an onay/red pulse is not arbitrated; the next grant comes after it.
        if ((|istek) && (r_onay == '0) && (r_red == '0)) begin
          w_idx_nxt   = w_sec;
          w_rota_nxt  = w_sec_kod;
          w_durum_nxt = KONTROL;
        end
      end
      KONTROL: begin
        if (w_rota_dogru) begin
          w_gecerli_nxt    = 1'b1;
          w_cikis_rota_nxt = r_rota;
          w_kaynak_nxt     = r_idx;
          w_sayac_nxt      = '0;
          w_durum_nxt      = ILET;
        end else begin
          w_red_nxt   = w_tek;
          w_hata_nxt  = doyarak_artir(r_hata);
          w_durum_nxt = RED;
        end
      end
      ILET: begin
        if (cikis_hazir) begin
          w_onay_nxt    = w_tek;
          w_gecerli_nxt = 1'b0;
          w_son_nxt     = r_idx;
          w_durum_nxt   = BOS;
        end else if (r_sayac == 8'(TIMEOUT - 1)) begin
          w_red_nxt     = w_tek;
          w_gecerli_nxt = 1'b0;
          w_hata_nxt    = doyarak_artir(r_hata);
          w_son_nxt     = r_idx;
          w_durum_nxt   = BOS;
        end else begin
          w_sayac_nxt = r_sayac + 8'd1;
        end
      end
      RED: begin
        w_son_nxt   = r_idx;
        w_durum_nxt = BOS;
      end
      default: w_durum_nxt = BOS;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_durum      <= BOS;
      r_idx        <= '0;
      r_son        <= 3'(N_IST - 1);
      r_rota       <= '0;
      r_sayac      <= '0;
      r_onay       <= '0;
      r_red        <= '0;
      r_gecerli    <= 1'b0;
      r_cikis_rota <= '0;
      r_kaynak     <= '0;
      r_hata       <= '0;
    end else begin
      r_durum      <= w_durum_nxt;
      r_idx        <= w_idx_nxt;
      r_son        <= w_son_nxt;
      r_rota       <= w_rota_nxt;
      r_sayac      <= w_sayac_nxt;
      r_onay       <= w_onay_nxt;
      r_red        <= w_red_nxt;
      r_gecerli    <= w_gecerli_nxt;
      r_cikis_rota <= w_cikis_rota_nxt;
      r_kaynak     <= w_kaynak_nxt;
      r_hata       <= w_hata_nxt;
    end
  end

  assign onay          = r_onay;
  assign red           = r_red;
  assign cikis_gecerli = r_gecerli;
  assign cikis_rota    = r_cikis_rota;
  assign cikis_kaynak  = r_kaynak;
  assign hata_sayac    = r_hata;
  assign o_durum       = r_durum;

endmodule

// File: tb/tb_rota_planlayici.sv
// Directed bench for rota_planlayici: vector table of single transactions plus hand-written
// sequences for reset, fairness, backpressure/timeout and error-counter saturation.
module tb_rota_planlayici;

  logic        clk;
  logic        rst_n;
  logic [3:0]  istek;
  logic [23:0] rota_in;
  logic [3:0]  onay;
  logic [3:0]  red;
  logic        cikis_gecerli;
  logic        cikis_hazir;
  logic [5:0]  cikis_rota;
  logic [2:0]  cikis_kaynak;
  logic [7:0]  hata_sayac;
  logic [1:0]  o_durum;

  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] exp_hata;
  logic [2:0] exp_q[$];

  rota_planlayici #(.N_IST(4), .TIMEOUT(15)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .istek         (istek),
    .rota_in       (rota_in),
    .onay          (onay),
    .red           (red),
    .cikis_gecerli (cikis_gecerli),
    .cikis_hazir   (cikis_hazir),
    .cikis_rota    (cikis_rota),
    .cikis_kaynak  (cikis_kaynak),
    .hata_sayac    (hata_sayac),
    .o_durum       (o_durum)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", n_errors);
    $fatal(1, "watchdog expired");
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] sat_inc(input logic [7:0] d);
    return (d == 8'hFF) ? 8'hFF : d + 8'd1;
  endfunction

  task automatic set_kod(input int i, input logic [5:0] kod);
    rota_in[6*i +: 6] = kod;
  endtask

  typedef struct {
    logic [3:0] istek;
    logic [5:0] kod;
    logic       exp_gecerli;
    logic [2:0] exp_kaynak;
  } vec_t;

  vec_t vt[8];

  initial begin
    int   n_onay;
    int   ilk_cyc;
    int   n_stabil;
    int   kacak;
    logic bitti;
    logic [2:0] e;

    vt[0] = '{4'b0100, 6'b100101, 1'b1, 3'd2};
    vt[1] = '{4'b0010, 6'b000000, 1'b0, 3'd1};
    vt[2] = '{4'b0001, 6'b111000, 1'b1, 3'd0};
    vt[3] = '{4'b1000, 6'b100011, 1'b1, 3'd3};
    vt[4] = '{4'b0010, 6'b100110, 1'b1, 3'd1};
    vt[5] = '{4'b0001, 6'b111001, 1'b0, 3'd0};
    vt[6] = '{4'b0100, 6'b100111, 1'b0, 3'd2};
    vt[7] = '{4'b1000, 6'b011000, 1'b0, 3'd3};

    rst_n       = 1'b0;
    istek       = '0;
    rota_in     = '0;
    cikis_hazir = 1'b0;
    exp_hata    = '0;

    // reset values
    repeat (2) @(posedge clk);
    #1;
    chk("rst_onay", 32'(onay), 32'h0);
    chk("rst_red", 32'(red), 32'h0);
    chk("rst_gecerli", 32'(cikis_gecerli), 32'h0);
    chk("rst_rota", 32'(cikis_rota), 32'h0);
    chk("rst_kaynak", 32'(cikis_kaynak), 32'h0);
    chk("rst_hata", 32'(hata_sayac), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("idle_durum", 32'(o_durum), 32'd0);

    // single-transaction vector table, downstream always ready
    cikis_hazir = 1'b1;
    for (int v = 0; v < 8; v++) begin
      rota_in = 24'($urandom());
      set_kod(int'(vt[v].exp_kaynak), vt[v].kod);
      istek = vt[v].istek;
      tick();
      chk($sformatf("v%0d_durum_kontrol", v), 32'(o_durum), 32'd1);
      chk($sformatf("v%0d_gecerli_erken", v), 32'(cikis_gecerli), 32'h0);
      tick();
      chk($sformatf("v%0d_gecerli", v), 32'(cikis_gecerli), 32'(vt[v].exp_gecerli));
      if (vt[v].exp_gecerli) begin
        chk($sformatf("v%0d_rota", v), 32'(cikis_rota), 32'(vt[v].kod));
        chk($sformatf("v%0d_kaynak", v), 32'(cikis_kaynak), 32'(vt[v].exp_kaynak));
        chk($sformatf("v%0d_red_yok", v), 32'(red), 32'h0);
      end else begin
        exp_hata = sat_inc(exp_hata);
        chk($sformatf("v%0d_red", v), 32'(red), 32'(vt[v].istek));
        chk($sformatf("v%0d_hata", v), 32'(hata_sayac), 32'(exp_hata));
      end
      tick();
      if (vt[v].exp_gecerli) begin
        chk($sformatf("v%0d_onay", v), 32'(onay), 32'(vt[v].istek));
        chk($sformatf("v%0d_gecerli_dustu", v), 32'(cikis_gecerli), 32'h0);
      end else begin
        chk($sformatf("v%0d_red_tek_pals", v), 32'(red | onay), 32'h0);
      end
      istek = '0;
      tick();
      tick();
    end

    // fairness: all four requesting continuously
    for (int i = 0; i < 4; i++) set_kod(i, 6'b111000);
    exp_q = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd0};
    istek = 4'b1111;
    n_onay = 0;
    ilk_cyc = -1;
    for (int c = 1; c <= 40 && n_onay < 5; c++) begin
      tick();
      if (onay != 4'b0000) begin
        if (ilk_cyc < 0) ilk_cyc = c;
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk($sformatf("t4_onay_%0d", n_onay), 32'(onay), 32'(4'b0001 << e));
        end
        n_onay++;
      end
    end
    chk("t4_onay_sayisi", 32'(n_onay), 32'd5);
    chk("t4_ilk_onay_gecikme", 32'(ilk_cyc), 32'd3);
    istek = '0;
    tick();
    tick();

    // backpressure held off until timeout
    cikis_hazir = 1'b0;
    set_kod(3, 6'b100011);
    istek = 4'b1000;
    tick();
    tick();
    n_stabil = 0;
    bitti = 1'b0;
    for (int c = 0; c < 25 && !bitti; c++) begin
      if (red != 4'b0000) begin
        bitti = 1'b1;
      end else begin
        if (cikis_gecerli && cikis_rota == 6'b100011 && cikis_kaynak == 3'd3) n_stabil++;
        tick();
      end
    end
    exp_hata = sat_inc(exp_hata);
    chk("t5_zaman_asimi_red", 32'(red), 32'h8);
    chk("t5_stabil_cevrim", 32'(n_stabil), 32'd15);
    chk("t5_gecerli_dustu", 32'(cikis_gecerli), 32'h0);
    chk("t5_onay_yok", 32'(onay), 32'h0);
    chk("t5_hata", 32'(hata_sayac), 32'(exp_hata));
    istek = '0;
    tick();
    tick();

    // backpressure released before timeout
    istek = 4'b1000;
    tick();
    tick();
    chk("t5b_gecerli", 32'(cikis_gecerli), 32'h1);
    kacak = 0;
    for (int c = 0; c < 3; c++) begin
      tick();
      if (red != 4'b0000 || onay != 4'b0000) kacak++;
    end
    chk("t5b_erken_pals_yok", 32'(kacak), 32'd0);
    chk("t5b_gecerli_bekliyor", 32'(cikis_gecerli), 32'h1);
    cikis_hazir = 1'b1;
    tick();
    chk("t5b_onay", 32'(onay), 32'h8);
    chk("t5b_red_yok", 32'(red), 32'h0);
    chk("t5b_hata_ayni", 32'(hata_sayac), 32'(exp_hata));
    istek = '0;
    tick();
    tick();

    // asynchronous reset in the middle of ILET
    cikis_hazir = 1'b0;
    set_kod(0, 6'b111000);
    istek = 4'b0001;
    tick();
    tick();
    chk("t1_iletde", 32'(cikis_gecerli), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("t1_rst_gecerli", 32'(cikis_gecerli), 32'h0);
    chk("t1_rst_rota", 32'(cikis_rota), 32'h0);
    chk("t1_rst_hata", 32'(hata_sayac), 32'h0);
    chk("t1_rst_pals", 32'(onay | red), 32'h0);
    exp_hata = '0;
    for (int i = 0; i < 4; i++) set_kod(i, 6'b100110);
    istek = 4'b1111;
    cikis_hazir = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("t1_rst_durum", 32'(o_durum), 32'd0);
    rst_n = 1'b1;
    tick();
    tick();
    chk("t1_ilk_kaynak", 32'(cikis_kaynak), 32'd0);
    chk("t1_ilk_gecerli", 32'(cikis_gecerli), 32'h1);
    tick();
    chk("t1_ilk_onay", 32'(onay), 32'h1);
    istek = '0;
    tick();
    tick();

    // error counter saturation
    set_kod(1, 6'b000000);
    kacak = 0;
    for (int n = 0; n < 260; n++) begin
      istek = 4'b0010;
      tick();
      tick();
      if (red != 4'b0010) kacak++;
      exp_hata = sat_inc(exp_hata);
      istek = '0;
      tick();
      if (n == 99) chk("t6_hata_100", 32'(hata_sayac), 32'd100);
    end
    chk("t6_red_kacak", 32'(kacak), 32'd0);
    chk("t6_hata_doygun", 32'(hata_sayac), 32'hFF);
    chk("t6_model_doygun", 32'(hata_sayac), 32'(exp_hata));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
